// File: rtl/accel_spi_reader_if.sv
// Pin and sample bundle between the accelerometer SPI reader and its surroundings.
// master: the reader (drives SPI pins and samples); slave: accelerometer/consumer side.
interface accel_spi_reader_if;
  logic              spi_cs_n;
  logic              spi_sclk;
  logic              spi_mosi;
  logic              spi_miso;
  logic signed [7:0] accel_data_x;
  logic signed [7:0] accel_data_y;
  logic              data_valid;
  logic              id_error;

  modport master (
    output spi_cs_n, spi_sclk, spi_mosi,
    output accel_data_x, accel_data_y, data_valid, id_error,
    input  spi_miso
  );

  modport slave (
    input  spi_cs_n, spi_sclk, spi_mosi,
    input  accel_data_x, accel_data_y, data_valid, id_error,
    output spi_miso
  );
endinterface

// File: rtl/accel_spi_reader.sv
// SPI mode-3 master: configures an ADXL345-class accelerometer and polls X/Y every POLL_CYCLES.
// Optional device-ID check before configuration is enabled by defining ACCEL_ID_CHECK_EN.
module accel_spi_reader #(
  parameter int SCLK_DIV    = 9,
  parameter int POLL_CYCLES = 36000
) (
  input  logic               pixel_clk,
  input  logic               rst,
  accel_spi_reader_if.master bus
);
  localparam int DW = $clog2(SCLK_DIV);
  localparam int GW = $clog2(2 * SCLK_DIV);
  localparam int PW = $clog2(POLL_CYCLES);
  localparam logic [DW-1:0] DIV_LAST  = DW'(SCLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(2 * SCLK_DIV - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);

  typedef enum logic [2:0] {
`ifdef ACCEL_ID_CHECK_EN
    ST_INIT_ID,
`endif
    ST_INIT_FMT, ST_INIT_PWR, ST_WAIT, ST_READ, ST_UPDATE
  } state_e;

  typedef enum logic [1:0] {PH_GAP, PH_SETUP, PH_BITS, PH_HOLD} phase_e;

`ifdef ACCEL_ID_CHECK_EN
  localparam state_e RESET_ST = ST_INIT_ID;
  localparam logic [7:0] DEVID = 8'hE5;
`else
  localparam state_e RESET_ST = ST_INIT_FMT;
`endif

  state_e            state_q, state_d;
  phase_e            phase_q, phase_d;
  logic [DW-1:0]     div_q, div_d;
  logic [5:0]        bit_q, bit_d;
  logic              half_q, half_d;
  logic              cs_n_q, cs_n_d, sclk_q, sclk_d, mosi_q, mosi_d;
  logic [31:0]       rx_q, rx_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [PW-1:0]     poll_q, poll_d;
  logic signed [7:0] x_q, x_d, y_q, y_d;
  logic              dv_q, dv_d;
  logic              gap_done, start;
`ifdef ACCEL_ID_CHECK_EN
  logic              id_err_q, id_err_d;
`endif

  function automatic logic [7:0] tx_byte(input state_e s, input logic [2:0] idx);
    tx_byte = 8'h00;
    case (s)
`ifdef ACCEL_ID_CHECK_EN
      ST_INIT_ID:  tx_byte = (idx == 3'd0) ? 8'h80 : 8'h00;
`endif
      ST_INIT_FMT: tx_byte = (idx == 3'd0) ? 8'h31 : 8'h00;
      ST_INIT_PWR: tx_byte = (idx == 3'd0) ? 8'h2D : 8'h08;
      ST_READ:     tx_byte = (idx == 3'd0) ? 8'hF2 : 8'h00;
      default:     tx_byte = 8'h00;
    endcase
  endfunction

  function automatic logic tx_bit(input state_e s, input logic [5:0] b);
    logic [7:0] byte_v;
    byte_v = tx_byte(s, b[5:3]);
    return byte_v[3'd7 - b[2:0]];
  endfunction

  function automatic logic [5:0] last_bit(input state_e s);
    return (s == ST_READ) ? 6'd39 : 6'd15;
  endfunction

  // 10-bit signed sample down to 8 bits; arithmetic shift keeps the sign.
  function automatic logic signed [7:0] to_sample(input logic signed [9:0] raw);
    return 8'(raw >>> 2);
  endfunction

  assign gap_done = (gap_q == GAP_LAST);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    div_d   = div_q;
    bit_d   = bit_q;
    half_d  = half_q;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    rx_d    = rx_q;
    x_d     = x_q;
    y_d     = y_q;
    dv_d    = 1'b0;
    start   = 1'b0;
`ifdef ACCEL_ID_CHECK_EN
    id_err_d = id_err_q;
`endif
    gap_d  = !cs_n_q ? '0 : (gap_done ? gap_q : gap_q + 1'b1);
    poll_d = (poll_q == POLL_LAST) ? poll_q : poll_q + 1'b1;

    case (phase_q)
      PH_GAP: begin
        case (state_q)
          ST_WAIT: begin
            if (gap_done && poll_q == POLL_LAST) begin
`ifdef ACCEL_ID_CHECK_EN
              state_d = id_err_q ? ST_INIT_ID : ST_READ;
`else
              state_d = ST_READ;
`endif
              start = 1'b1;
            end
          end
          ST_UPDATE: begin
            x_d     = to_sample({rx_q[17:16], rx_q[31:24]});
            y_d     = to_sample({rx_q[1:0], rx_q[15:8]});
            dv_d    = 1'b1;
            state_d = ST_WAIT;
          end
          default: start = gap_done;
        endcase
      end
      PH_SETUP: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          phase_d = PH_BITS;
          half_d  = 1'b0;
          bit_d   = 6'd0;
          sclk_d  = 1'b0;
          mosi_d  = tx_bit(state_q, 6'd0);
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      PH_BITS: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (!half_q) begin
            sclk_d = 1'b1;
            half_d = 1'b1;
            rx_d   = {rx_q[30:0], bus.spi_miso};
          end else if (bit_q == last_bit(state_q)) begin
            phase_d = PH_HOLD;
          end else begin
            bit_d  = bit_q + 6'd1;
            half_d = 1'b0;
            sclk_d = 1'b0;
            mosi_d = tx_bit(state_q, bit_q + 6'd1);
          end
        end
      end
      default: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d   = '0;
          cs_n_d  = 1'b1;
          mosi_d  = 1'b0;
          phase_d = PH_GAP;
          case (state_q)
`ifdef ACCEL_ID_CHECK_EN
            ST_INIT_ID: begin
              id_err_d = (rx_q[7:0] != DEVID);
              state_d  = (rx_q[7:0] == DEVID) ? ST_INIT_FMT : ST_WAIT;
            end
`endif
            ST_INIT_FMT: state_d = ST_INIT_PWR;
            ST_INIT_PWR: begin
              state_d = ST_WAIT;
              poll_d  = '0;
            end
            ST_READ: state_d = ST_UPDATE;
            default: state_d = state_q;
          endcase
        end
      end
    endcase

    // Poll period is measured from each CS falling edge so reads stay evenly spaced.
    if (start) begin
      cs_n_d  = 1'b0;
      phase_d = PH_SETUP;
      div_d   = '0;
      poll_d  = '0;
    end
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      state_q <= RESET_ST;
      phase_q <= PH_GAP;
      div_q   <= '0;
      bit_q   <= '0;
      half_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b1;
      mosi_q  <= 1'b0;
      rx_q    <= '0;
      gap_q   <= '0;
      poll_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      dv_q    <= 1'b0;
`ifdef ACCEL_ID_CHECK_EN
      id_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      half_q  <= half_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      rx_q    <= rx_d;
      gap_q   <= gap_d;
      poll_q  <= poll_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dv_q    <= dv_d;
`ifdef ACCEL_ID_CHECK_EN
      id_err_q <= id_err_d;
`endif
    end
  end

  // High bits of DATAX1/DATAY1 are unused in 10-bit mode.
  logic unused_rx;
  assign unused_rx = ^{rx_q[23:18], rx_q[7:2]};

  assign bus.spi_cs_n     = cs_n_q;
  assign bus.spi_sclk     = sclk_q;
  assign bus.spi_mosi     = mosi_q;
  assign bus.accel_data_x = x_q;
  assign bus.accel_data_y = y_q;
  assign bus.data_valid   = dv_q;
`ifdef ACCEL_ID_CHECK_EN
  assign bus.id_error     = id_err_q;
`else
  assign bus.id_error     = 1'b0;
`endif
endmodule

// File: tb/tb_accel_spi_reader.sv
// Bench for accel_spi_reader: mode-3 accelerometer slave model, transaction monitor and sample scoreboard.
module tb_accel_spi_reader;
  localparam int SCLK_DIV = 2;
  localparam int POLL     = 400;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  accel_spi_reader_if bus ();

  accel_spi_reader #(.SCLK_DIV(SCLK_DIV), .POLL_CYCLES(POLL)) dut (
    .pixel_clk (clk),
    .rst       (rst),
    .bus       (bus.master)
  );

  typedef struct {
    logic [39:0] bytes;
    int          nrise;
    int          low;
    int          fall;
    int          rise;
  } txn_t;

  txn_t        txq[$];
  logic [15:0] exp_q[$];
  logic [7:0]  sd [4];
  logic [7:0]  devid = 8'hE5;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic resp_bit(input int r, input logic [7:0] cmd);
    logic [7:0] b;
    int k;
    k = r / 8;
    if (k == 0)                     b = 8'hFF;
    else if (cmd == 8'hF2 && k < 5) b = sd[k-1];
    else if (cmd == 8'h80)          b = devid;
    else                            b = 8'h00;
    return b[7 - (r % 8)];
  endfunction

  // Monitor, slave model and scoreboard, all sampled mid-cycle.
  logic        prev_cs = 1'b1, prev_sclk = 1'b1;
  int          cur_rises = 0, cur_low = 0, cur_fall = 0;
  logic [39:0] cur_sr = '0;
  logic [7:0]  cur_cmd = '0;
  int          idle_viol = 0;
  int          dv_len = 0;
  logic [15:0] e;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_cs   = 1'b1;
      prev_sclk = 1'b1;
      cur_rises = 0;
      dv_len    = 0;
    end else begin
      if (bus.spi_cs_n && !bus.spi_sclk) idle_viol++;
      if (prev_cs && !bus.spi_cs_n) begin
        cur_fall  = cyc;
        cur_rises = 0;
        cur_low   = 0;
        cur_sr    = '0;
        cur_cmd   = '0;
      end
      if (!bus.spi_cs_n) begin
        cur_low++;
        if (!prev_sclk && bus.spi_sclk) begin
          cur_sr = {cur_sr[38:0], bus.spi_mosi};
          cur_rises++;
          if (cur_rises == 8) cur_cmd = cur_sr[7:0];
        end
        if (prev_sclk && !bus.spi_sclk) bus.spi_miso = resp_bit(cur_rises, cur_cmd);
      end
      if (!prev_cs && bus.spi_cs_n) txq.push_back('{cur_sr, cur_rises, cur_low, cur_fall, cyc});
      if (bus.data_valid) begin
        dv_len++;
        if (exp_q.size() == 0) chk("dv_unexpected", bus.data_valid, 1'b0);
        else begin
          e = exp_q.pop_front();
          chk("data_x", $unsigned(bus.accel_data_x), e[15:8]);
          chk("data_y", $unsigned(bus.accel_data_y), e[7:0]);
        end
      end else if (dv_len != 0) begin
        chk("dv_width", dv_len, 1);
        dv_len = 0;
      end
      prev_cs   = bus.spi_cs_n;
      prev_sclk = bus.spi_sclk;
    end
  end

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  endtask

  task automatic wait_txn(input int n);
    for (int i = 0; i < 5000 && txq.size() < n; i++) @(negedge clk);
    chk("txn_timeout", txq.size() >= n, 1'b1);
    if (txq.size() < n) finish_run();
  endtask

  task automatic wait_dv();
    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(negedge clk);
    chk("dv_timeout", exp_q.size(), 0);
  endtask

  initial begin
    bus.spi_miso = 1'b1;
    sd = '{8'h40, 8'h01, 8'hFC, 8'h03};
`ifdef ACCEL_ID_CHECK_EN
    devid = 8'hE4;
`endif
    repeat (3) @(negedge clk);
    chk("rst_cs_n", bus.spi_cs_n, 1'b1);
    chk("rst_sclk", bus.spi_sclk, 1'b1);
    chk("rst_mosi", bus.spi_mosi, 1'b0);
    chk("rst_x", $unsigned(bus.accel_data_x), 8'h00);
    chk("rst_y", $unsigned(bus.accel_data_y), 8'h00);
    chk("rst_dv", bus.data_valid, 1'b0);
    chk("rst_id_error", bus.id_error, 1'b0);
    rst = 1'b0;

`ifdef ACCEL_ID_CHECK_EN
    wait_txn(2);
    chk("id_cmd0", txq[0].bytes[15:8], 8'h80);
    chk("id_cmd1", txq[1].bytes[15:8], 8'h80);
    chk("id_retry_period", txq[1].fall - txq[0].fall, POLL);
    chk("id_error_set", bus.id_error, 1'b1);
    devid = 8'hE5;
    wait_txn(3);
    @(negedge clk);
    chk("id_cmd2", txq[2].bytes[15:8], 8'h80);
    chk("id_error_clr", bus.id_error, 1'b0);
    txq.delete();
`endif

    exp_q.push_back({8'h50, 8'hFF});
    wait_txn(3);
    chk("fmt_bytes", txq[0].bytes[15:0], 16'h3100);
    chk("fmt_rises", txq[0].nrise, 16);
    chk("fmt_low", txq[0].low, 34 * SCLK_DIV);
    chk("pwr_bytes", txq[1].bytes[15:0], 16'h2D08);
    chk("init_gap_ok", (txq[1].fall - txq[0].rise) >= 2 * SCLK_DIV, 1'b1);
    chk("read1_cmd", txq[2].bytes[39:32], 8'hF2);
    chk("read1_rises", txq[2].nrise, 40);
    chk("read1_low", txq[2].low, 82 * SCLK_DIV);
    wait_dv();

    sd = '{8'h00, 8'h02, 8'hFF, 8'h01};
    exp_q.push_back({8'h80, 8'h7F});
    wait_txn(4);
    wait_dv();
    chk("read2_cmd", txq[3].bytes[39:32], 8'hF2);
    chk("read2_period", txq[3].fall - txq[2].fall, POLL);

    exp_q.push_back({8'h80, 8'h7F});
    wait_txn(5);
    wait_dv();
    chk("read3_period", txq[4].fall - txq[3].fall, POLL);
    chk("read3_rises", txq[4].nrise, 40);
    chk("read3_low", txq[4].low, 82 * SCLK_DIV);

    // Abort the next read inside its third byte.
    for (int i = 0; i < 1000 && !(cur_fall > txq[4].fall && cur_rises >= 18); i++) @(negedge clk);
    chk("mid_read_reached", (cur_fall > txq[4].fall) && (cur_rises >= 17) && (cur_rises <= 23), 1'b1);
    rst = 1'b1;
    #1;
    chk("abort_cs_n", bus.spi_cs_n, 1'b1);
    chk("abort_sclk", bus.spi_sclk, 1'b1);
    chk("abort_mosi", bus.spi_mosi, 1'b0);
    chk("abort_x", $unsigned(bus.accel_data_x), 8'h00);
    chk("abort_y", $unsigned(bus.accel_data_y), 8'h00);
    repeat (3) @(negedge clk);
    txq.delete();
    rst = 1'b0;
    wait_txn(1);
`ifdef ACCEL_ID_CHECK_EN
    chk("restart_cmd", txq[0].bytes[15:8], 8'h80);
`else
    chk("restart_cmd", txq[0].bytes[15:8], 8'h31);
`endif
    chk("restart_x", $unsigned(bus.accel_data_x), 8'h00);
    chk("sclk_idle_high", idle_viol, 0);
    finish_run();
  end
endmodule
